// File: rtl/rv32_exec_wb.sv
`default_nettype none
// ============================================================================
// Module      : rv32_exec_wb
// Description : RV32I execute/write-back stage with the 32x32 register file,
//               EX/WB pipeline, full operand forwarding and a debug port.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32_exec_wb #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [3:0]      alu_ctrl,
    input  logic            reg_write,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [4:0]      rd,
    output logic            wb_valid,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic [31:0]     instret,
    input  logic            dbg_we,
    input  logic [4:0]      dbg_addr,
    input  logic [XLEN-1:0] dbg_wdata,
    output logic [XLEN-1:0] dbg_rdata
);

    localparam logic [3:0] c_OP_AND = 4'b0000;
    localparam logic [3:0] c_OP_OR  = 4'b0001;
    localparam logic [3:0] c_OP_ADD = 4'b0010;
    localparam logic [3:0] c_OP_SLL = 4'b0011;
    localparam logic [3:0] c_OP_SUB = 4'b0100;
    localparam logic [3:0] c_OP_SRL = 4'b0101;
    localparam logic [3:0] c_OP_XOR = 4'b0111;
    localparam logic [3:0] c_OP_SLT = 4'b1000;

    logic [XLEN-1:0] r_rf [32];

    logic            r_ex_valid;
    logic            r_ex_we;
    logic [3:0]      r_ex_ctrl;
    logic [4:0]      r_ex_rd;
    logic [XLEN-1:0] r_ex_op1;
    logic [XLEN-1:0] r_ex_op2;

    logic            r_wb_valid;
    logic            r_wb_we;
    logic [4:0]      r_wb_rd;
    logic [XLEN-1:0] r_wb_data;
    logic [31:0]     r_instret;

    logic [XLEN-1:0] w_alu;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;

    // r_ex_we / r_wb_we already exclude rd==0, so x0 can never match a bypass.
    always_comb begin
        w_op1 = '0;
        if (rs1 != 5'd0) begin
            if (r_ex_valid && r_ex_we && (r_ex_rd == rs1))
                w_op1 = w_alu;
            else if (r_wb_valid && r_wb_we && (r_wb_rd == rs1))
                w_op1 = r_wb_data;
            else
                w_op1 = r_rf[rs1];
        end
    end

    always_comb begin
        w_op2 = '0;
        if (rs2 != 5'd0) begin
            if (r_ex_valid && r_ex_we && (r_ex_rd == rs2))
                w_op2 = w_alu;
            else if (r_wb_valid && r_wb_we && (r_wb_rd == rs2))
                w_op2 = r_wb_data;
            else
                w_op2 = r_rf[rs2];
        end
    end

    always_comb begin
        w_alu = '0;
        case (r_ex_ctrl)
            c_OP_AND: w_alu = r_ex_op1 & r_ex_op2;
            c_OP_OR:  w_alu = r_ex_op1 | r_ex_op2;
            c_OP_ADD: w_alu = r_ex_op1 + r_ex_op2;
            c_OP_SLL: w_alu = r_ex_op1 << r_ex_op2[4:0];
            c_OP_SUB: w_alu = r_ex_op1 - r_ex_op2;
            c_OP_SRL: w_alu = r_ex_op1 >> r_ex_op2[4:0];
            c_OP_XOR: w_alu = r_ex_op1 ^ r_ex_op2;
            c_OP_SLT: w_alu = {{(XLEN-1){1'b0}}, ($signed(r_ex_op1) < $signed(r_ex_op2))};
            default:  w_alu = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid <= 1'b0;
            r_ex_we    <= 1'b0;
            r_ex_ctrl  <= '0;
            r_ex_rd    <= '0;
            r_ex_op1   <= '0;
            r_ex_op2   <= '0;
        end else begin
            r_ex_valid <= in_valid;
            r_ex_we    <= in_valid && reg_write && (rd != 5'd0);
            r_ex_ctrl  <= alu_ctrl;
            r_ex_rd    <= rd;
            r_ex_op1   <= w_op1;
            r_ex_op2   <= w_op2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_valid <= 1'b0;
            r_wb_we    <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_instret  <= '0;
        end else begin
            r_wb_valid <= r_ex_valid;
            r_wb_we    <= r_ex_valid && r_ex_we;
            r_wb_rd    <= r_ex_rd;
            r_wb_data  <= w_alu;
            if (r_wb_valid)
                r_instret <= r_instret + 32'd1;
        end
    end

    // The pipeline write is issued last so it overrides a debug write to the same index.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++)
                r_rf[i] <= '0;
        end else begin
            if (dbg_we && (dbg_addr != 5'd0))
                r_rf[dbg_addr] <= dbg_wdata;
            if (r_wb_we)
                r_rf[r_wb_rd] <= r_wb_data;
        end
    end

    assign wb_valid  = r_wb_valid;
    assign wb_we     = r_wb_we;
    assign wb_rd     = r_wb_rd;
    assign wb_data   = r_wb_data;
    assign instret   = r_instret;
    assign dbg_rdata = (dbg_addr == 5'd0) ? '0 : r_rf[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_rv32_exec_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32_exec_wb
// Description : Directed self-checking bench for rv32_exec_wb.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32_exec_wb;

    localparam logic [3:0] c_AND = 4'b0000;
    localparam logic [3:0] c_OR  = 4'b0001;
    localparam logic [3:0] c_ADD = 4'b0010;
    localparam logic [3:0] c_SLL = 4'b0011;
    localparam logic [3:0] c_SUB = 4'b0100;
    localparam logic [3:0] c_SRL = 4'b0101;
    localparam logic [3:0] c_XOR = 4'b0111;
    localparam logic [3:0] c_SLT = 4'b1000;
    localparam logic [3:0] c_UND = 4'b0110;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [3:0]  alu_ctrl;
    logic        reg_write;
    logic [4:0]  rs1, rs2, rd;
    logic        wb_valid, wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] instret;
    logic        dbg_we;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic [31:0] dbg_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    rv32_exec_wb #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .alu_ctrl(alu_ctrl),
        .reg_write(reg_write), .rs1(rs1), .rs2(rs2), .rd(rd),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .instret(instret), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        reg_write = 1'b0;
        dbg_we    = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op, input logic rw, input logic [4:0] d,
                         input logic [4:0] a, input logic [4:0] b);
        in_valid  = 1'b1;
        alu_ctrl  = op;
        reg_write = rw;
        rd        = d;
        rs1       = a;
        rs2       = b;
    endtask

    task automatic dbg_write(input logic [4:0] a, input logic [31:0] v);
        dbg_we    = 1'b1;
        dbg_addr  = a;
        dbg_wdata = v;
        tick();
        dbg_we    = 1'b0;
    endtask

    task automatic dbg_check(input logic [4:0] a, input logic [31:0] exp, input string tag);
        dbg_addr = a;
        #1;
        check(tag, dbg_rdata, exp);
    endtask

    // Single non-overlapped instruction: accept, EX, then check WB output.
    task automatic run_one(input logic [3:0] op, input logic [4:0] d, input logic [4:0] a,
                           input logic [4:0] b, input logic [31:0] exp, input string tag);
        issue(op, 1'b1, d, a, b);
        tick();
        idle();
        tick();
        check(tag, wb_data, exp);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        alu_ctrl = '0; rs1 = '0; rs2 = '0; rd = '0;
        dbg_addr = '0; dbg_wdata = '0;
        tick(); tick();
        rst = 1'b0;

        // Random traffic, then a 2-cycle reset while traffic continues
        for (int i = 0; i < 12; i++) begin
            if (i == 10) rst = 1'b1;
            in_valid  = 1'($urandom);
            alu_ctrl  = 4'($urandom);
            reg_write = 1'($urandom);
            rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom);
            dbg_we    = 1'($urandom);
            dbg_addr  = 5'($urandom);
            dbg_wdata = $urandom;
            tick();
        end
        rst = 1'b0;
        idle();
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_wb_we",    {31'd0, wb_we},    32'd0);
        check("rst_wb_rd",    {27'd0, wb_rd},    32'd0);
        check("rst_wb_data",  wb_data,           32'd0);
        check("rst_instret",  instret,           32'd0);
        for (int a = 0; a < 32; a++)
            dbg_check(5'(a), 32'd0, $sformatf("rst_x%0d", a));

        // Basic add
        tick();
        dbg_write(5'd1, 32'd5);
        dbg_write(5'd2, 32'd3);
        issue(c_ADD, 1'b1, 5'd3, 5'd1, 5'd2);
        tick();
        idle();
        check("add_n1_valid", {31'd0, wb_valid}, 32'd0);
        tick();
        check("add_valid", {31'd0, wb_valid}, 32'd1);
        check("add_we",    {31'd0, wb_we},    32'd1);
        check("add_rd",    {27'd0, wb_rd},    32'd3);
        check("add_data",  wb_data,           32'd8);
        check("add_instret_n2", instret,      32'd0);
        dbg_check(5'd3, 32'd0, "add_x3_n2");
        tick();
        dbg_check(5'd3, 32'd8, "add_x3_n3");
        check("add_instret", instret, 32'd1);

        // Forwarding chain with stale register values that would expose a missing bypass
        dbg_write(5'd3, 32'h0000_00F0);
        dbg_write(5'd4, 32'h0000_00FF);
        issue(c_ADD, 1'b1, 5'd3, 5'd1, 5'd2);
        tick();
        issue(c_SUB, 1'b1, 5'd4, 5'd3, 5'd1);
        tick();
        issue(c_AND, 1'b1, 5'd5, 5'd4, 5'd3);
        check("chain_add", wb_data, 32'd8);
        tick();
        idle();
        check("chain_sub", wb_data, 32'd3);
        tick();
        check("chain_and", wb_data, 32'd0);
        tick();
        dbg_check(5'd4, 32'd3, "chain_x4");

        // EX bypass must win over WB bypass for the same index
        issue(c_ADD, 1'b1, 5'd13, 5'd1, 5'd2);
        tick();
        issue(c_ADD, 1'b1, 5'd13, 5'd13, 5'd1);
        tick();
        issue(c_ADD, 1'b1, 5'd14, 5'd13, 5'd0);
        check("prio_a", wb_data, 32'd8);
        tick();
        idle();
        check("prio_b", wb_data, 32'd13);
        tick();
        check("prio_c", wb_data, 32'd13);
        tick();

        // ALU edge cases
        dbg_write(5'd1, 32'hFFFF_FFFF);
        dbg_write(5'd2, 32'd1);
        dbg_write(5'd7, 32'd33);
        run_one(c_SLT, 5'd6,  5'd1, 5'd2, 32'd1,          "slt_neg_pos");
        run_one(c_SLT, 5'd6,  5'd2, 5'd1, 32'd0,          "slt_pos_neg");
        run_one(c_SLL, 5'd8,  5'd2, 5'd7, 32'd2,          "sll_33");
        run_one(c_SRL, 5'd9,  5'd1, 5'd2, 32'h7FFF_FFFF,  "srl_logical");
        run_one(c_SUB, 5'd10, 5'd2, 5'd1, 32'd2,          "sub_wrap");
        run_one(c_XOR, 5'd15, 5'd1, 5'd2, 32'hFFFF_FFFE,  "xor");
        run_one(c_OR,  5'd15, 5'd2, 5'd7, 32'd33,         "or");
        run_one(c_UND, 5'd15, 5'd1, 5'd2, 32'd0,          "undef_op");

        // x0 destination is never written nor forwarded
        issue(c_ADD, 1'b1, 5'd0, 5'd7, 5'd2);
        tick();
        issue(c_ADD, 1'b1, 5'd11, 5'd0, 5'd2);
        tick();
        idle();
        check("x0_valid", {31'd0, wb_valid}, 32'd1);
        check("x0_we",    {31'd0, wb_we},    32'd0);
        tick();
        check("x11_we",   {31'd0, wb_we},    32'd1);
        check("x11_data", wb_data,           32'd1);
        tick();
        dbg_check(5'd0,  32'd0, "x0_stays_0");
        dbg_check(5'd11, 32'd1, "x11_value");
        dbg_write(5'd0, 32'hDEAD_BEEF);
        dbg_check(5'd0, 32'd0, "dbg_x0_ignored");

        // reg_write=0 still retires but leaves the register file untouched
        issue(c_ADD, 1'b0, 5'd12, 5'd7, 5'd2);
        tick();
        idle();
        tick();
        check("nowr_valid", {31'd0, wb_valid}, 32'd1);
        check("nowr_we",    {31'd0, wb_we},    32'd0);
        check("nowr_rd",    {27'd0, wb_rd},    32'd12);
        tick();
        dbg_check(5'd12, 32'd0, "nowr_x12");
        check("instret_18", instret, 32'd18);

        // Reset mid-flight discards in-flight work and the same-cycle instruction
        issue(c_ADD, 1'b1, 5'd12, 5'd7, 5'd2);
        tick();
        rst = 1'b1;
        issue(c_ADD, 1'b1, 5'd13, 5'd7, 5'd2);
        tick();
        rst = 1'b0;
        idle();
        check("mid_rst_valid_a", {31'd0, wb_valid}, 32'd0);
        tick();
        check("mid_rst_valid_b", {31'd0, wb_valid}, 32'd0);
        dbg_check(5'd12, 32'd0, "mid_rst_x12");
        dbg_check(5'd13, 32'd0, "mid_rst_x13");
        check("mid_rst_instret", instret, 32'd0);

        // Debug/pipeline collision and same-cycle debug visibility
        dbg_write(5'd1, 32'd5);
        dbg_write(5'd2, 32'd3);
        issue(c_ADD, 1'b1, 5'd3, 5'd1, 5'd2);
        tick();
        idle();
        tick();
        dbg_we = 1'b1; dbg_addr = 5'd3; dbg_wdata = 32'h77;
        tick();
        dbg_we = 1'b0;
        dbg_check(5'd3, 32'd8, "collision_x3");

        issue(c_ADD, 1'b1, 5'd4, 5'd1, 5'd2);
        dbg_we = 1'b1; dbg_addr = 5'd1; dbg_wdata = 32'd100;
        tick();
        dbg_we = 1'b0;
        issue(c_ADD, 1'b1, 5'd5, 5'd1, 5'd2);
        tick();
        idle();
        check("dbg_same_cycle", wb_data, 32'd8);
        tick();
        check("dbg_next_cycle", wb_data, 32'd103);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rv32_exec_wb.md
# rv32_exec_wb

Execute/write-back stage of the RV32I core, directly downstream of the instruction control decoder. Each cycle it can accept one decoded instruction: `alu_ctrl` and `reg_write` from the decoder, plus `rs1`/`rs2`/`rd` register indices. It owns the 32x32 architectural register file and runs a two-stage pipeline (EX, WB) with full forwarding. A debug port lets the bench or the SoC loader seed and inspect registers, since the current decoder supports only R-type instructions.

## Interface
Parameters:
- `XLEN`, 32, datapath width. Only 32 is supported.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  a decoded instruction is present this cycle. It is always accepted; there is no backpressure.
- `alu_ctrl`  in  4  operation code: AND=0000, OR=0001, ADD=0010, SLL=0011, SUB=0100, SRL=0101, XOR=0111, SLT=1000.
- `reg_write`  in  1  the instruction writes `rd`.
- `rs1`, `rs2`, `rd`  in  5 each  register indices.
- `wb_valid`  out  1  an instruction retires this cycle.
- `wb_we`  out  1  the retiring instruction writes the register file (`reg_write` set and `rd`≠0).
- `wb_rd`  out  5  destination index of the retiring instruction.
- `wb_data`  out  32  result of the retiring instruction.
- `instret`  out  32  count of retired instructions; wraps at 2^32.
- `dbg_we`  in  1  debug write enable.
- `dbg_addr`  in  5  debug read/write index.
- `dbg_wdata`  in  32  debug write data.
- `dbg_rdata`  out  32  combinational read of the architectural register file; no forwarding applied.

## Operation
- Accept stage (cycle N):
  - Operands are read from the register file, with bypass.
  - Bypass priority: EX-stage ALU result, then WB-stage result, then register file.
  - A bypass source is used only if it is valid, has `reg_write` set, has `rd`≠0, and its `rd` equals the operand index.
  - Index 0 always reads 0.
  - The EX register captures valid, operands, `alu_ctrl`, `rd` and `reg_write`.
- EX stage (cycle N+1): the ALU computes from the EX register; the result is captured into the WB register.
  - ADD/SUB: modulo 2^32.
  - SLT: signed compare, result 1 or 0.
  - SLL/SRL: shift amount is operand2[4:0]; SRL is logical.
  - AND/OR/XOR: bitwise.
  - Undefined codes produce 0.
- WB stage (cycle N+2): the WB register drives the `wb_*` outputs. If `wb_we` is set, the register file is written at the end of cycle N+2. `instret` increments at the same edge.
- `in_valid`=1 with `reg_write`=0 still flows through the pipeline and retires: `wb_valid`=1, `wb_we`=0.
- Writes to x0 are dropped. x0 is never forwarded.
- Debug write: takes effect at the end of the cycle it is asserted.
  - It is visible through the register file to instructions accepted in the next cycle.
  - It is not visible to an instruction accepted in the same cycle.
  - A pipeline write to the same index in the same cycle wins; the debug write is lost.
  - A debug write to x0 is ignored.

## Timing
- Latency: an instruction accepted in cycle N appears on `wb_*` in cycle N+2. `dbg_rdata` shows its result from cycle N+3.
- Throughput: one instruction per cycle. Back-to-back dependent instructions need no stall because of forwarding.
- Reset (synchronous), on the first edge with `rst` high:
  - EX and WB valid bits clear.
  - All 32 registers clear to 0.
  - `instret` clears to 0.
  - `wb_valid`, `wb_we`, `wb_rd` and `wb_data` read 0.
- Reset mid-operation: in-flight instructions are discarded, with no register write and no retire. An instruction presented in the same cycle as `rst` is not accepted.
- After `rst` falls, the first instruction is accepted in the first cycle with `rst` low.

## Test plan
- Reset: hold `rst` 2 cycles after random traffic, then sweep `dbg_addr` 0–31 -> every `dbg_rdata`=0, `wb_valid`=0, `instret`=0.
- Basic add: debug-write x1=5 and x2=3, then issue ADD rd=3, rs1=1, rs2=2 in cycle N -> `wb_valid`=1, `wb_we`=1, `wb_rd`=3, `wb_data`=8 in N+2; `dbg_rdata`(x3)=8 from N+3; `instret`=1.
- Forwarding chain: with x1=5 and x2=3, issue ADD x3=x1+x2, then SUB x4=x3-x1, then AND x5=x4&x3, in consecutive cycles -> `wb_data` = 8, then 3, then 0 in consecutive cycles.
- ALU edges:
  - x1=0xFFFFFFFF, x2=1: SLT x6=x1,x2 -> 1; SLT x6=x2,x1 -> 0.
  - x7=33: SLL x8=x2,x7 -> 2.
  - SRL x9=x1,x2 -> 0x7FFFFFFF.
  - SUB x10=x2,x1 -> 2.
- x0 and no-write cases:
  - ADD rd=0, then ADD x11=x0+x2 next cycle -> `wb_we`=0 on the first, 1 on the second; x0 stays 0; x11=1.
  - `reg_write`=0 instruction -> `wb_valid`=1, `wb_we`=0, and the register is unchanged.
- Reset mid-flight and debug collision:
  - Issue ADD x12 in N and assert `rst` in N+1 -> no `wb_valid` and x12=0.
  - `dbg_we` to x3 in the same cycle as a WB write to x3 -> the pipeline value is stored.
